// File: rtl/pixel_shade_accum.sv
// Per-pixel colour resolver: issues triangle requests, waits a fixed model latency,
// combines hits (nearest-Z or saturating add) and emits one pixel word per pixel.
module pixel_shade_accum #(
  parameter int unsigned X_MAX         = 640,
  parameter int unsigned Y_MAX         = 480,
  parameter int unsigned COLOR_W       = 10,
  parameter int unsigned Z_W           = 20,
  parameter int unsigned MODEL_LATENCY = 2,
  parameter int unsigned XY_W          = 10
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode,
  output logic               request_triangle,
  input  logic               all_triangles_read,
  input  logic               intersected_tri,
  input  logic [Z_W-1:0]     intersect_z,
  input  logic [COLOR_W-1:0] intersect_r,
  input  logic [COLOR_W-1:0] intersect_g,
  input  logic [COLOR_W-1:0] intersect_b,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [XY_W-1:0]    wr_x,
  output logic [XY_W-1:0]    wr_y,
  output logic [COLOR_W-1:0] wr_r,
  output logic [COLOR_W-1:0] wr_g,
  output logic [COLOR_W-1:0] wr_b,
  output logic [7:0]         hit_count,
  output logic               frame_done
);

  localparam int unsigned LatW = (MODEL_LATENCY > 1) ? $clog2(MODEL_LATENCY) : 1;
  localparam logic [LatW-1:0]    LatLast  = LatW'(MODEL_LATENCY - 1);
  localparam logic [XY_W-1:0]    XLast    = XY_W'(X_MAX - 1);
  localparam logic [XY_W-1:0]    YLast    = XY_W'(Y_MAX - 1);
  localparam logic [COLOR_W-1:0] ColorMax = {COLOR_W{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StSample,
    StWrite
  } state_e;

  state_e             state_q, state_d;
  logic [LatW-1:0]    lat_q, lat_d;
  logic               mode_q, mode_d;
  logic               hit_q, hit_d;
  logic [7:0]         hits_q, hits_d;
  logic [Z_W-1:0]     nz_q, nz_d;
  logic [COLOR_W-1:0] acc_r_q, acc_r_d;
  logic [COLOR_W-1:0] acc_g_q, acc_g_d;
  logic [COLOR_W-1:0] acc_b_q, acc_b_d;
  logic [XY_W-1:0]    x_q, x_d;
  logic [XY_W-1:0]    y_q, y_d;
  logic               start_pixel;
  logic               accept;

  function automatic logic [COLOR_W-1:0] sat_add(input logic [COLOR_W-1:0] a,
                                                 input logic [COLOR_W-1:0] b);
    logic [COLOR_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COLOR_W] ? ColorMax : sum[COLOR_W-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    mode_d      = mode_q;
    hit_d       = hit_q;
    hits_d      = hits_q;
    nz_d        = nz_q;
    acc_r_d     = acc_r_q;
    acc_g_d     = acc_g_q;
    acc_b_d     = acc_b_q;
    x_d         = x_q;
    y_d         = y_q;
    start_pixel = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          start_pixel = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        lat_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (lat_q == LatLast) begin
          state_d = StSample;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StSample: begin
        if (intersected_tri) begin
          if (mode_q) begin
            acc_r_d = sat_add(acc_r_q, intersect_r);
            acc_g_d = sat_add(acc_g_q, intersect_g);
            acc_b_d = sat_add(acc_b_q, intersect_b);
          end else if (!hit_q || (intersect_z < nz_q)) begin
            // Strict compare: on equal depth the earlier triangle keeps the pixel.
            acc_r_d = intersect_r;
            acc_g_d = intersect_g;
            acc_b_d = intersect_b;
            nz_d    = intersect_z;
          end
          hit_d = 1'b1;
          if (hits_q != 8'hFF) begin
            hits_d = hits_q + 8'd1;
          end
        end
        state_d = all_triangles_read ? StWrite : StIssue;
      end
      StWrite: begin
        if (wr_ready) begin
          accept = 1'b1;
          if (x_q == XLast) begin
            x_d = '0;
            y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (enable) begin
            start_pixel = 1'b1;
            state_d     = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A new pixel starts from a clean slate with the mode sampled right now.
    if (start_pixel) begin
      mode_d  = mode;
      hit_d   = 1'b0;
      hits_d  = '0;
      nz_d    = '0;
      acc_r_d = '0;
      acc_g_d = '0;
      acc_b_d = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lat_q   <= '0;
      mode_q  <= 1'b0;
      hit_q   <= 1'b0;
      hits_q  <= '0;
      nz_q    <= '0;
      acc_r_q <= '0;
      acc_g_q <= '0;
      acc_b_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      mode_q  <= mode_d;
      hit_q   <= hit_d;
      hits_q  <= hits_d;
      nz_q    <= nz_d;
      acc_r_q <= acc_r_d;
      acc_g_q <= acc_g_d;
      acc_b_q <= acc_b_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign request_triangle = (state_q == StIssue);
  assign wr_valid         = (state_q == StWrite);
  assign wr_x             = x_q;
  assign wr_y             = y_q;
  assign wr_r             = acc_r_q;
  assign wr_g             = acc_g_q;
  assign wr_b             = acc_b_q;
  assign hit_count        = hits_q;
  assign frame_done       = accept && (x_q == XLast) && (y_q == YLast);

endmodule

// File: tb/tb_pixel_shade_accum.sv
// Self-checking bench for pixel_shade_accum on a 4x2 screen with a behavioural
// pixel model (nearest-Z / saturating sum over the triangle list).
module tb_pixel_shade_accum;

  localparam int TX  = 4;
  localparam int TY  = 2;
  localparam int CW  = 10;
  localparam int ZW  = 20;
  localparam int LAT = 2;
  localparam int XYW = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic           sys_clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic           mode = 1'b0;
  logic           request_triangle;
  logic           all_triangles_read = 1'b0;
  logic           intersected_tri = 1'b0;
  logic [ZW-1:0]  intersect_z = '0;
  logic [CW-1:0]  intersect_r = '0;
  logic [CW-1:0]  intersect_g = '0;
  logic [CW-1:0]  intersect_b = '0;
  logic           wr_valid;
  logic           wr_ready = 1'b1;
  logic [XYW-1:0] wr_x;
  logic [XYW-1:0] wr_y;
  logic [CW-1:0]  wr_r;
  logic [CW-1:0]  wr_g;
  logic [CW-1:0]  wr_b;
  logic [7:0]     hit_count;
  logic           frame_done;

  pixel_shade_accum #(
    .X_MAX(TX), .Y_MAX(TY), .COLOR_W(CW), .Z_W(ZW), .MODEL_LATENCY(LAT), .XY_W(XYW)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .enable(enable), .mode(mode),
    .request_triangle(request_triangle), .all_triangles_read(all_triangles_read),
    .intersected_tri(intersected_tri), .intersect_z(intersect_z),
    .intersect_r(intersect_r), .intersect_g(intersect_g), .intersect_b(intersect_b),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b), .hit_count(hit_count), .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  int fd_cnt = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  int checks = 0;
  int errors = 0;
  int ex = 0;
  int ey = 0;
  int obs_r, obs_g, obs_h;

  // Triangle list presented for the current pixel.
  int tz[8], tr[8], tg[8], tbl[8];
  bit th[8];

  function automatic void model(input bit m, input int n, output int er, output int eg,
                                output int eb, output int eh);
    int best, cnt, sr, sg, sb;
    best = -1; cnt = 0; sr = 0; sg = 0; sb = 0;
    for (int k = 0; k < n; k++) begin
      if (th[k]) begin
        cnt++;
        sr += tr[k]; sg += tg[k]; sb += tbl[k];
        if (best < 0 || tz[k] < tz[best]) best = k;
      end
    end
    if (m) begin
      er = (sr > CMAX) ? CMAX : sr;
      eg = (sg > CMAX) ? CMAX : sg;
      eb = (sb > CMAX) ? CMAX : sb;
    end else begin
      er = (best < 0) ? 0 : tr[best];
      eg = (best < 0) ? 0 : tg[best];
      eb = (best < 0) ? 0 : tbl[best];
    end
    eh = (cnt > 255) ? 255 : cnt;
  endfunction

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      tz[k] = $urandom_range(0, 15);
      tr[k] = $urandom_range(0, CMAX);
      tg[k] = $urandom_range(0, CMAX);
      tbl[k] = $urandom_range(0, CMAX);
      th[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Serves one pixel of n triangles and checks the emitted word. m_next is driven on
  // mode just before acceptance so the following pixel latches it.
  task automatic do_pixel(input bit m, input bit m_next, input int n, input int stall,
                          input bit scramble);
    int er, eg, eb, eh, t0, tprev, waited;
    logic [XYW-1:0] sx, sy;
    logic [CW-1:0] sr, sg, sb;
    logic [7:0] sh;
    bit exp_fd;
    model(m, n, er, eg, eb, eh);
    t0 = 0; tprev = 0;
    for (int k = 0; k < n; k++) begin
      waited = 0;
      while (request_triangle !== 1'b1 && waited < 50) begin
        @(negedge sys_clk);
        waited++;
      end
      if (waited >= 50) begin
        errors++;
        $display("FAIL request_timeout got none want pulse (tri %0d)", k);
        return;
      end
      if (k == 0) begin
        t0 = cyc;
        if (stall > 0) wr_ready = 1'b0;
      end else begin
        checks++;
        if (cyc - tprev != LAT + 2) begin
          errors++;
          $display("FAIL request_spacing got %0d want %0d", cyc - tprev, LAT + 2);
        end
      end
      tprev = cyc;
      intersect_z = ZW'(tz[k]);
      intersect_r = CW'(tr[k]);
      intersect_g = CW'(tg[k]);
      intersect_b = CW'(tbl[k]);
      intersected_tri = th[k];
      all_triangles_read = (k == n - 1);
      if (scramble && k == 0) mode = ~m;
      @(negedge sys_clk);
    end
    waited = 0;
    while (wr_valid !== 1'b1 && waited < 50) begin
      @(negedge sys_clk);
      waited++;
    end
    if (waited >= 50) begin
      errors++;
      $display("FAIL write_timeout got wr_valid=%b want 1", wr_valid);
      return;
    end
    if (stall == 0) begin
      checks++;
      if (cyc - t0 != n * (LAT + 2)) begin
        errors++;
        $display("FAIL pixel_latency got %0d want %0d", cyc - t0, n * (LAT + 2));
      end
    end else begin
      sx = wr_x; sy = wr_y; sr = wr_r; sg = wr_g; sb = wr_b; sh = hit_count;
      for (int i = 0; i < stall; i++) begin
        checks++;
        if (wr_valid !== 1'b1 || request_triangle !== 1'b0 || frame_done !== 1'b0 ||
            wr_x !== sx || wr_y !== sy || wr_r !== sr || wr_g !== sg || wr_b !== sb ||
            hit_count !== sh) begin
          errors++;
          $display("FAIL stall_hold cycle %0d got v=%b req=%b x=%0d r=%0d want v=1 req=0 x=%0d r=%0d",
                   i, wr_valid, request_triangle, wr_x, wr_r, sx, sr);
        end
        @(negedge sys_clk);
      end
      wr_ready = 1'b1;
    end
    #1;
    obs_r = int'(wr_r); obs_g = int'(wr_g); obs_h = int'(hit_count);
    checks++;
    if (wr_x !== XYW'(ex) || wr_y !== XYW'(ey)) begin
      errors++;
      $display("FAIL coord got (%0d,%0d) want (%0d,%0d)", wr_x, wr_y, ex, ey);
    end
    checks++;
    if (wr_r !== CW'(er) || wr_g !== CW'(eg) || wr_b !== CW'(eb)) begin
      errors++;
      $display("FAIL colour mode %0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
               m, wr_r, wr_g, wr_b, er, eg, eb);
    end
    checks++;
    if (hit_count !== 8'(eh)) begin
      errors++;
      $display("FAIL hit_count got %0d want %0d", hit_count, eh);
    end
    exp_fd = (ex == TX - 1) && (ey == TY - 1);
    checks++;
    if (frame_done !== exp_fd) begin
      errors++;
      $display("FAIL frame_done got %b want %b at (%0d,%0d)", frame_done, exp_fd, ex, ey);
    end
    mode = m_next;
    if (ex == TX - 1) begin
      ex = 0;
      ey = (ey == TY - 1) ? 0 : ey + 1;
    end else begin
      ex++;
    end
    @(negedge sys_clk);
    checks++;
    if (request_triangle !== 1'b1 || wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_bubble got req=%b v=%b want req=1 v=0", request_triangle, wr_valid);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (request_triangle !== 1'b0 || wr_valid !== 1'b0 || wr_x !== '0 || wr_y !== '0 ||
        wr_r !== '0 || wr_g !== '0 || wr_b !== '0 || hit_count !== '0 ||
        frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s got req=%b v=%b x=%0d y=%0d rgb=%0d,%0d,%0d h=%0d fd=%b want all 0",
               tag, request_triangle, wr_valid, wr_x, wr_y, wr_r, wr_g, wr_b, hit_count,
               frame_done);
    end
  endtask

  task automatic release_and_check(input string tag);
    @(negedge sys_clk);
    reset = 1'b0;
    enable = 1'b1;
    ex = 0; ey = 0;
    #1;
    checks++;
    if (request_triangle !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_req got %b want 0", tag, request_triangle);
    end
    @(negedge sys_clk);
    checks++;
    if (request_triangle !== 1'b1) begin
      errors++;
      $display("FAIL %s_first_req got %b want 1", tag, request_triangle);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; mode = 1'b0; wr_ready = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset_state");
    release_and_check("reset");
    fill_random(1);
    th[0] = 1'b1;
    do_pixel(1'b0, 1'b0, 1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_wait;
    @(negedge sys_clk);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_mid_wait");
    release_and_check("rerelease");
  endtask

  task automatic test_nearest;
    fill_random(3);
    tz[0] = 500; tr[0] = 100; th[0] = 1'b1;
    tz[1] = 200; tr[1] = 7;   th[1] = 1'b1;
    tz[2] = 200; tr[2] = 9;   th[2] = 1'b1;
    do_pixel(1'b0, 1'b1, 3, 0, 1'b0);
    checks++;
    if (obs_r != 7 || obs_h != 3) begin
      errors++;
      $display("FAIL nearest_const got r=%0d h=%0d want r=7 h=3", obs_r, obs_h);
    end
  endtask

  task automatic test_saturate;
    fill_random(3);
    tr[0] = 600; tg[0] = 3; th[0] = 1'b1;
    tr[1] = 600; tg[1] = 4; th[1] = 1'b1;
    tr[2] = 900; tg[2] = 900; th[2] = 1'b0;
    do_pixel(1'b1, 1'b0, 3, 0, 1'b0);
    checks++;
    if (obs_r != CMAX || obs_g != 7 || obs_h != 2) begin
      errors++;
      $display("FAIL saturate_const got r=%0d g=%0d h=%0d want r=%0d g=7 h=2",
               obs_r, obs_g, obs_h, CMAX);
    end
  endtask

  task automatic test_backpressure;
    fill_random(2);
    do_pixel(1'b0, 1'b1, 2, 20, 1'b0);
  endtask

  task automatic test_mode_latch;
    fill_random(2);
    tz[0] = 10; tr[0] = 5; th[0] = 1'b1;
    tz[1] = 20; tr[1] = 6; th[1] = 1'b1;
    do_pixel(1'b1, 1'b0, 2, 0, 1'b1);
    checks++;
    if (obs_r != 11) begin
      errors++;
      $display("FAIL mode_latch_old got r=%0d want 11", obs_r);
    end
    do_pixel(1'b0, 1'b0, 2, 0, 1'b0);
    checks++;
    if (obs_r != 5) begin
      errors++;
      $display("FAIL mode_latch_new got r=%0d want 5", obs_r);
    end
  endtask

  task automatic test_back_to_back;
    bit cur, nxt;
    cur = 1'b0;
    for (int p = 0; p < 12; p++) begin
      int n;
      n = $urandom_range(1, 5);
      nxt = (p == 11) ? 1'b0 : 1'($urandom_range(0, 1));
      fill_random(n);
      do_pixel(cur, nxt, n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      cur = nxt;
    end
  endtask

  task automatic test_wrap;
    int fd0;
    @(negedge sys_clk);
    reset = 1'b1; mode = 1'b0;
    @(negedge sys_clk);
    release_and_check("wrap");
    #1 fd0 = fd_cnt;
    for (int p = 0; p < TX * TY; p++) begin
      fill_random(1);
      do_pixel(1'b0, 1'b0, 1, 0, 1'b0);
    end
    #1;
    checks++;
    if (fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL frame_done_count got %0d want 1", fd_cnt - fd0);
    end
    fill_random(1);
    do_pixel(1'b0, 1'b0, 1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_nearest();
    test_saturate();
    test_backpressure();
    test_mode_latch();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/pixel_shade_accum.md
Name: pixel_shade_accum

Overview:
- Per-pixel colour resolver for the ray-tracing pipeline.
- For every screen pixel it requests triangles one at a time from the triangle reader and waits a fixed model latency. It then combines each intersection result, by nearest-Z or by saturating additive accumulation.
- When the last triangle has been processed, it emits one pixel word with a valid/ready handshake toward the SDRAM write FIFO.
- It generalises the previous fixed-latency, add-only pixel loop: parametrised screen size, widths and latency, selectable combine mode, and write backpressure.

Parameters:
- X_MAX, 640, pixels per line; x runs 0..X_MAX-1.
- Y_MAX, 480, lines per frame; y runs 0..Y_MAX-1.
- COLOR_W, 10, bits per colour channel.
- Z_W, 20, bits of intersection depth (unsigned).
- MODEL_LATENCY, 2, cycles from request_triangle to a valid intersection result; must be >= 1.
- XY_W, 10, width of the pixel coordinate outputs.

Ports:
- sys_clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- enable  in  1  allows a new pixel to start.
- mode  in  1  0 = nearest-Z, 1 = additive accumulate; latched at pixel start.
- request_triangle  out  1  one-cycle pulse asking the reader for the next triangle.
- all_triangles_read  in  1  high when the current result belongs to the last triangle of the pixel.
- intersected_tri  in  1  the current triangle was hit.
- intersect_z  in  Z_W  hit depth.
- intersect_r / intersect_g / intersect_b  in  COLOR_W each  hit colour.
- wr_valid  out  1  pixel word available.
- wr_ready  in  1  SDRAM write side accepts the word.
- wr_x, wr_y  out  XY_W each  coordinate of the pixel word.
- wr_r, wr_g, wr_b  out  COLOR_W each  resolved colour.
- hit_count  out  8  hits counted for the emitted pixel; saturates at 255.
- frame_done  out  1  one-cycle pulse when pixel (X_MAX-1, Y_MAX-1) is accepted.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; all outputs 0; x=y=0; accumulators, nearest_z and the hit flag cleared.
- Reset mid-operation aborts the pixel. The word is lost and restart is at (0,0).

States:
- IDLE: if enable, latch mode, clear acc_r/g/b, hit flag and hits, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: request_triangle=1 for exactly this cycle; lat_cnt<=0; go to WAIT.
- WAIT: lat_cnt increments each cycle. When lat_cnt==MODEL_LATENCY-1, go to SAMPLE. The sample therefore occurs MODEL_LATENCY+1 cycles after the ISSUE cycle.
- SAMPLE: combine the inputs (rules below). If all_triangles_read=1, go to WRITE; otherwise go to ISSUE.
- WRITE: wr_valid=1, with wr_x/y/r/g/b/hit_count stable until wr_valid&&wr_ready.
  - On acceptance, advance the coordinate.
  - If enable, go to ISSUE with accumulators cleared and mode relatched in the same cycle (no IDLE bubble); otherwise go to IDLE.

Combine rules, applied only when intersected_tri=1 in SAMPLE:
- mode 0: take the colour if no hit yet, or if intersect_z < nearest_z (strict; on a tie the earlier triangle wins). Update nearest_z and set the hit flag.
- mode 1: acc_c <= min(acc_c + intersect_c, 2^COLOR_W-1) per channel. Use a COLOR_W+1 bit sum; saturate when the carry is set.
- hit_count increments (saturating at 255) in both modes.
- With no hits, the pixel is emitted as 0,0,0 with hit_count=0.

Coordinate advance on acceptance:
- x==X_MAX-1 → x<=0, and y<=(y==Y_MAX-1)?0:y+1; otherwise x<=x+1.
- frame_done pulses in the acceptance cycle of (X_MAX-1, Y_MAX-1).

Other rules:
- mode and enable changes mid-pixel are ignored until the next pixel start.
- wr_valid is never deasserted without acceptance.
- all_triangles_read and the intersect inputs are ignored outside SAMPLE.
- Throughput with wr_ready=1 and N triangles: N*(MODEL_LATENCY+2)+1 cycles per pixel.

Test Plan:
- Reset: assert reset mid-WAIT, asynchronously → all outputs 0 immediately. After release with enable=1, request_triangle pulses on the 2nd cycle after reset release (IDLE→ISSUE, pulse in ISSUE); the first word is at (0,0).
- Nearest-Z, mode=0, 3 triangles:
  - hits z=500 (r=100), z=200 (r=7), z=200 (r=9), last flagged on the 3rd.
  - Expect wr_r=7, hit_count=3.
  - Request spacing is MODEL_LATENCY+2=4 cycles.
- Saturating add, mode=1, 2 triangles:
  - r=600 then r=600 → wr_r=1023.
  - g=3 then g=4 → wr_g=7.
  - A non-hit third triangle leaves values unchanged.
- Backpressure: hold wr_ready=0 for 20 cycles → wr_valid stays 1 with data stable, and no request_triangle pulses. Raise wr_ready → one acceptance, x advances by 1.
- Wrap: X_MAX=4, Y_MAX=2, 1 triangle/pixel → 8 words in raster order (0,0)..(3,1), frame_done exactly once (on (3,1)), the next word at (0,0).
- Mode latch: toggle mode mid-pixel → the current pixel uses the old mode; the next pixel uses the new mode.
